// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: word stores in one cycle, loads in two, and
// sub-word stores as a read-modify-write against a 1-cycle-latency BRAM.
module dmem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e              state_q, state_d;
  logic [ADDR_W+1:0]   addr_q;
  logic [1:0]          size_q;
  logic [15:0]         wdata_q;
  logic                unsigned_q;
  logic                latch_en;

  logic                req_fault;
  logic [31:0]         load_ext;
  logic [31:0]         merged;
  logic [7:0]          byte_val;
  logic [15:0]         half_val;

  assign req_fault = (req_size == 2'b11)
                   || (req_size == SZ_HALF && req_addr[0])
                   || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                   || (req_addr[31:ADDR_W+2] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      unsigned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q     <= req_addr[ADDR_W+1:0];
        size_q     <= req_size;
        wdata_q    <= req_wdata[15:0];
        unsigned_q <= req_unsigned;
      end
    end
  end

  assign byte_val = mem_rdata[8*addr_q[1:0] +: 8];
  assign half_val = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ext = mem_rdata;
    case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
      SZ_HALF: load_ext = unsigned_q ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
      default: load_ext = mem_rdata;
    endcase
  end

  // Per-lane merge for RMW: odd lanes of a halfword take the upper store byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic hit;
      assign hit = (size_q == SZ_BYTE && addr_q[1:0] == LANE)
                || (size_q == SZ_HALF && addr_q[1] == LANE[1]);
      assign merged[8*gi +: 8] = hit
          ? ((size_q == SZ_HALF && LANE[0]) ? wdata_q[15:8] : wdata_q[7:0])
          : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    latch_en    = 1'b0;
    stall       = 1'b0;
    rdata       = '0;
    rdata_valid = 1'b0;
    fault       = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_fault) begin
            fault = 1'b1;
          end else if (req_write && req_size == SZ_WORD) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = req_addr[ADDR_W+1:2];
            mem_wdata = req_wdata;
          end else begin
            mem_en   = 1'b1;
            mem_addr = req_addr[ADDR_W+1:2];
            stall    = 1'b1;
            latch_en = 1'b1;
            state_d  = req_write ? RMW : LOAD;
          end
        end
      end
      LOAD: begin
        rdata_valid = 1'b1;
        rdata       = load_ext;
        state_d     = IDLE;
      end
      RMW: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q[ADDR_W+1:2];
        mem_wdata = merged;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset silences every output so an abandoned RMW can never write.
    if (rst) begin
      latch_en    = 1'b0;
      stall       = 1'b0;
      rdata       = '0;
      rdata_valid = 1'b0;
      fault       = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
    end
  end

endmodule
